// File: rtl/stick_dir_pkg.sv
// Shared constants and types for the stick-direction controller:
// register addresses, FSM state encoding, direction width and the
// auto-repeat prescaler divisor.
package stick_dir_pkg;

   localparam logic [1:0] ADDR_DIR    = 2'd0;
   localparam logic [1:0] ADDR_CTRL   = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_REPEAT = 2'd3;

   localparam int DIR_W    = 3;
   localparam int TICK_DIV = 1024;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } state_t;

endpackage

// File: rtl/stick_key_debounce.sv
// Pushbutton front end: 2-flop synchroniser for the asynchronous key_n
// pins, inversion to active-high k, and a debounce counter that accepts
// k as the stable value kd once it has been unchanged for
// DEBOUNCE_CYCLES cycles.
module stick_key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] key_n,
   output logic [1:0] kd
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

   logic [1:0]       sync1;
   logic [1:0]       sync2;
   logic [1:0]       k;
   logic [1:0]       k_last;
   logic [CNT_W-1:0] cnt;

   assign k = ~sync2;

   // Two-stage synchroniser; resets to "keys released".
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 2'b11;
         sync2 <= 2'b11;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
      end
   end

   // Reload the counter on any change of k; publish k once it has held.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         k_last <= 2'b00;
         cnt    <= '0;
         kd     <= 2'b00;
      end else if (k != k_last) begin
         k_last <= k;
         cnt    <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         kd <= k_last;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/nios_system_stick_dir_ctrl.sv
// Stick-direction controller on the Nios Avalon bus. The 3-bit direction
// register is shared between CPU writes and two debounced pushbuttons
// that step it modulo 8, with a hold delay and then auto-repeat.
// Optional build macro STICK_DIR_IRQ_EN adds the PEND/IE interrupt logic;
// without it STATUS and CTRL.IE read 0 and irq is tied low.
module nios_system_stick_dir_ctrl
   import stick_dir_pkg::*;
#(
   parameter int          DEBOUNCE_CYCLES = 500000,
   parameter logic [15:0] REPEAT_RESET    = 16'd12500,
   parameter int          HOLD_CYCLES     = 25000000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic [1:0]  key_n,
   output logic [2:0]  out_port,
   output logic        irq
);

   localparam int HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
   localparam int PRE_W  = $clog2(TICK_DIV);

   logic [1:0]       kd;
   logic             cw;
   logic             req;
   state_t           state, state_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
   logic [PRE_W-1:0] pre, pre_nxt;
   logic [15:0]      tick_cnt, tick_nxt;
   logic [1:0]       req_kd, req_kd_nxt;
   logic             step;
   logic [DIR_W-1:0] dir;
   logic             mode;
   logic [15:0]      rep_q;
   logic [15:0]      rep_eff;
   logic             pre_tick;
   logic             wr_en, wr_dir, wr_ctrl, wr_status, wr_repeat;
   logic             pend;
   logic             ie;
   logic             unused_bits;

   stick_key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .key_n  (key_n),
      .kd     (kd)
   );

   // kd==2'b11 and kd==2'b00 are both treated as no request.
   assign cw  = (kd == 2'b01);
   assign req = (kd == 2'b01) || (kd == 2'b10);

   assign wr_en     = chipselect && !write_n;
   assign wr_dir    = wr_en && (address == ADDR_DIR);
   assign wr_ctrl   = wr_en && (address == ADDR_CTRL);
   assign wr_status = wr_en && (address == ADDR_STATUS);
   assign wr_repeat = wr_en && (address == ADDR_REPEAT);

   assign rep_eff  = (rep_q == 16'd0) ? 16'd1 : rep_q;
   assign pre_tick = (pre == PRE_W'(TICK_DIV - 1));

   assign unused_bits = &{1'b0, writedata[31:16]};

   // Next-state logic: step decision, hold counter and repeat prescaler.
   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      pre_nxt      = '0;
      tick_nxt     = '0;
      req_kd_nxt   = req_kd;
      step         = 1'b0;
      if (mode) begin
         state_nxt    = IDLE;
         hold_cnt_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               hold_cnt_nxt = '0;
               if (req) begin
                  step       = 1'b1;
                  req_kd_nxt = kd;
                  state_nxt  = HOLD;
               end
            end
            HOLD: begin
               if (kd != req_kd) begin
                  state_nxt = IDLE;
               end else if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                  step      = 1'b1;
                  state_nxt = REPEAT;
               end else begin
                  hold_cnt_nxt = hold_cnt + 1'b1;
               end
            end
            REPEAT: begin
               if (kd != req_kd) begin
                  state_nxt = IDLE;
               end else begin
                  pre_nxt  = pre_tick ? '0 : pre + 1'b1;
                  tick_nxt = tick_cnt;
                  if (pre_tick) begin
                     if (tick_cnt == rep_eff - 16'd1) begin
                        step     = 1'b1;
                        tick_nxt = '0;
                     end else begin
                        tick_nxt = tick_cnt + 16'd1;
                     end
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // FSM state and counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         hold_cnt <= '0;
         pre      <= '0;
         tick_cnt <= '0;
         req_kd   <= 2'b00;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_cnt_nxt;
         pre      <= pre_nxt;
         tick_cnt <= tick_nxt;
         req_kd   <= req_kd_nxt;
      end
   end

   // Direction register: a CPU write to DIR beats a same-cycle key step.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dir   <= '0;
         mode  <= 1'b0;
         rep_q <= REPEAT_RESET;
      end else begin
         if (wr_dir) begin
            dir <= writedata[DIR_W-1:0];
         end else if (step) begin
            dir <= cw ? dir + 1'b1 : dir - 1'b1;
         end
         if (wr_ctrl) begin
            mode <= writedata[0];
         end
         if (wr_repeat) begin
            rep_q <= writedata[15:0];
         end
      end
   end

`ifdef STICK_DIR_IRQ_EN
   logic irq_q;
   logic key_step_applied;

   assign key_step_applied = step && !wr_dir;

   // PEND is set by applied key steps (set beats W1C); irq lags by one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend  <= 1'b0;
         ie    <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         if (key_step_applied) begin
            pend <= 1'b1;
         end else if (wr_status && writedata[0]) begin
            pend <= 1'b0;
         end
         if (wr_ctrl) begin
            ie <= writedata[1];
         end
         irq_q <= pend && ie;
      end
   end

   assign irq = irq_q;
`else
   assign pend = 1'b0;
   assign ie   = 1'b0;
   assign irq  = 1'b0;
`endif

   assign out_port = dir;

   // Zero-latency register read; unused bits read 0.
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DIR:    readdata[DIR_W-1:0] = dir;
         ADDR_CTRL:   readdata[1:0]       = {ie, mode};
         ADDR_STATUS: readdata[0]         = pend;
         ADDR_REPEAT: readdata[15:0]      = rep_q;
         default:     readdata            = '0;
      endcase
   end

endmodule

// File: tb/tb_nios_system_stick_dir_ctrl.sv
// Bench for the stick-direction controller: register-map vectors from a
// table, then hand-written key sequences for debounce, hold, repeat,
// arbitration, CPU-only mode and reset in the middle of auto-repeat.
module tb_nios_system_stick_dir_ctrl;

   localparam int DEB  = 4;
   localparam int HOLD = 20;
`ifdef STICK_DIR_IRQ_EN
   localparam logic IRQ_EN = 1'b1;
`else
   localparam logic IRQ_EN = 1'b0;
`endif

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [1:0]  key_n;
   logic [2:0]  out_port;
   logic        irq;

   int checks = 0;
   int errors = 0;

   nios_system_stick_dir_ctrl #(
      .DEBOUNCE_CYCLES(DEB),
      .HOLD_CYCLES    (HOLD)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (readdata),
      .key_n     (key_n),
      .out_port  (out_port),
      .irq       (irq)
   );

   // Clock and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic [1:0]  addr;
      logic        wr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic [2:0]  exp_out;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = readdata;
   endtask

   // Wait (bounded) for out_port to change; report cycles and new value.
   task automatic wait_change(input int limit, output int cycles, output logic [2:0] val);
      logic [2:0] start;
      start  = out_port;
      cycles = 0;
      while (out_port == start && cycles < limit) begin
         tick(1);
         cycles++;
      end
      val = out_port;
   endtask

   task automatic count_changes(input int n, output int changes);
      logic [2:0] last;
      last    = out_port;
      changes = 0;
      for (int i = 0; i < n; i++) begin
         tick(1);
         if (out_port != last) begin
            changes++;
            last = out_port;
         end
      end
   endtask

   initial begin
      logic [31:0] rd;
      int          c;
      int          changes;
      int          step_i;
      logic [2:0]  v;
      logic [2:0]  last;
      logic        irq_at;
      logic        irq_after;

      vecs[0] = '{2'd0, 1'b1, 32'h0000_0006, 32'h0000_0006, 3'd6};
      vecs[1] = '{2'd0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0001, 3'd1};
      vecs[2] = '{2'd1, 1'b1, 32'h0000_0003, {30'd0, IRQ_EN, 1'b1}, 3'd1};
      vecs[3] = '{2'd1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 3'd1};
      vecs[4] = '{2'd3, 1'b1, 32'hABCD_1234, 32'h0000_1234, 3'd1};
      vecs[5] = '{2'd2, 1'b1, 32'h0000_0001, 32'h0000_0000, 3'd1};
      vecs[6] = '{2'd3, 1'b1, 32'h0000_0000, 32'h0000_0000, 3'd1};
      vecs[7] = '{2'd3, 1'b1, 32'h0000_0001, 32'h0000_0001, 3'd1};
      vecs[8] = '{2'd0, 1'b0, 32'h0000_0000, 32'h0000_0001, 3'd1};
      vecs[9] = '{2'd0, 1'b1, 32'h0000_0000, 32'h0000_0000, 3'd0};

      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      key_n      = 2'b11;
      tick(3);
      reset_n = 1'b1;
      tick(1);

      // 1. reset state
      cpu_read(2'd0, rd); check("rst_dir", rd, 32'd0);
      cpu_read(2'd1, rd); check("rst_ctrl", rd, 32'd0);
      cpu_read(2'd2, rd); check("rst_status", rd, 32'd0);
      cpu_read(2'd3, rd); check("rst_repeat", rd, 32'd12500);
      check("rst_out", out_port, 3'd0);
      check("rst_irq", irq, 1'b0);

      // Register map vectors
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].wr) cpu_write(vecs[i].addr, vecs[i].wdata);
         cpu_read(vecs[i].addr, rd);
         check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
         check($sformatf("vec%0d_out", i), out_port, vecs[i].exp_out);
      end

      // 2. short press rejected, long press gives one step
      key_n = 2'b10;
      tick(3);
      key_n = 2'b11;
      count_changes(30, changes);
      check("t2_short_changes", changes, 0);

      cpu_write(2'd1, 32'h2);
      last = out_port; changes = 0; step_i = -1; irq_at = 1'b1; irq_after = 1'b0;
      key_n = 2'b10;
      for (int i = 0; i < 60; i++) begin
         if (i == 10) key_n = 2'b11;
         tick(1);
         if (step_i >= 0 && i == step_i + 1) irq_after = irq;
         if (out_port != last) begin
            changes++;
            last = out_port;
            if (step_i < 0) begin
               step_i = i;
               irq_at = irq;
            end
         end
      end
      check("t2_long_changes", changes, 1);
      check("t2_long_out", out_port, 3'd1);
      check("t2_irq_at_step", irq_at, 1'b0);
      check("t2_irq_after", irq_after, IRQ_EN);
      cpu_read(2'd2, rd); check("t2_pend", rd, {31'd0, IRQ_EN});
      cpu_write(2'd2, 32'h1);
      tick(1);
      check("t2_irq_cleared", irq, 1'b0);
      cpu_read(2'd2, rd); check("t2_pend_cleared", rd, 32'd0);

      // 3. wrap, hold delay, repeat spacing, release, ccw wrap
      cpu_write(2'd0, 32'h7);
      key_n = 2'b10;
      wait_change(40, c, v);
      check("t3_first_val", v, 3'd0);
      check("t3_first_bound", c <= 12, 1'b1);
      wait_change(30, c, v);
      check("t3_hold_cyc", c, HOLD);
      check("t3_hold_val", v, 3'd1);
      wait_change(1100, c, v);
      check("t3_rep1_cyc", c, 1024);
      check("t3_rep1_val", v, 3'd2);
      wait_change(1100, c, v);
      check("t3_rep2_cyc", c, 1024);
      check("t3_rep2_val", v, 3'd3);
      key_n = 2'b11;
      count_changes(1100, changes);
      check("t3_release_changes", changes, 0);
      cpu_write(2'd0, 32'h0);
      key_n = 2'b01;
      wait_change(40, c, v);
      check("t3_ccw_val", v, 3'd7);
      key_n = 2'b11;
      tick(30);

      // REPEAT=0 acts as 1, REPEAT=2 doubles the spacing
      cpu_write(2'd3, 32'h0);
      key_n = 2'b10;
      wait_change(40, c, v);
      check("t3r0_first_val", v, 3'd0);
      wait_change(30, c, v);
      check("t3r0_hold_cyc", c, HOLD);
      wait_change(1100, c, v);
      check("t3r0_rep_cyc", c, 1024);
      check("t3r0_rep_val", v, 3'd2);
      key_n = 2'b11;
      tick(30);
      cpu_write(2'd3, 32'h2);
      key_n = 2'b10;
      wait_change(40, c, v);
      wait_change(30, c, v);
      check("t3r2_hold_val", v, 3'd4);
      wait_change(2100, c, v);
      check("t3r2_rep_cyc", c, 2048);
      check("t3r2_rep_val", v, 3'd5);
      key_n = 2'b11;
      tick(30);
      cpu_write(2'd3, 32'h1);

      // 4. CPU write to DIR in the same cycle as the hold step
      cpu_write(2'd2, 32'h1);
      key_n = 2'b10;
      wait_change(40, c, v);
      check("t4_first_val", v, 3'd6);
      cpu_write(2'd2, 32'h1);
      tick(HOLD - 2);
      cpu_write(2'd0, 32'h5);
      check("t4_out", out_port, 3'd5);
      cpu_read(2'd2, rd); check("t4_pend", rd, 32'd0);
      wait_change(1100, c, v);
      check("t4_rep_cyc", c, 1024);
      check("t4_rep_val", v, 3'd6);

      // 5. CPU-only mode while repeating
      cpu_write(2'd1, 32'h1);
      count_changes(2100, changes);
      check("t5_mode_changes", changes, 0);
      cpu_write(2'd0, 32'h3);
      check("t5_cpu_dir", out_port, 3'd3);
      cpu_write(2'd1, 32'h2);
      wait_change(3, c, v);
      check("t5_idle_step_cyc", c, 1);
      check("t5_idle_step_val", v, 3'd4);
      wait_change(30, c, v);
      check("t5_hold_cyc", c, HOLD);
      check("t5_hold_val", v, 3'd5);

      // 6. reset in the middle of REPEAT
      tick(100);
      check("t6_irq_before", irq, IRQ_EN);
      reset_n = 1'b0;
      #2;
      check("t6_rst_out", out_port, 3'd0);
      check("t6_rst_irq", irq, 1'b0);
      cpu_read(2'd3, rd); check("t6_rst_repeat", rd, 32'd12500);
      tick(3);
      reset_n = 1'b1;
      wait_change(40, c, v);
      check("t6_first_val", v, 3'd1);
      check("t6_first_min", c >= DEB + 2, 1'b1);
      check("t6_first_max", c <= 12, 1'b1);
      wait_change(30, c, v);
      check("t6_hold_cyc", c, HOLD);
      check("t6_hold_val", v, 3'd2);
      check("t6_irq_ie0", irq, 1'b0);
      key_n = 2'b11;
      tick(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/nios_system_stick_dir_ctrl.md
Name: nios_system_stick_dir_ctrl

Overview:
- Controller for the 3-bit stick-direction output port on the Nios Avalon bus. Two requesters share the direction register: the CPU through Avalon writes, and two board pushbuttons that rotate the cue stick.
- Debounces the pushbuttons and steps the direction modulo 8, with auto-repeat while a key is held.
- Arbitrates CPU writes against key steps and drives out_port directly to the cue renderer.

Parameters:
- DEBOUNCE_CYCLES, 500000: cycles a key must be stable before it is accepted (10 ms at 50 MHz); minimum 2.
- REPEAT_RESET, 16'd12500: reset value of the REPEAT register, in units of 1024 cycles.
- HOLD_CYCLES, 25000000: cycles held after the first step before auto-repeat starts.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  Avalon word address
- chipselect  in  1  Avalon select
- write_n  in  1  Avalon write strobe, active low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data; combinational, zero-latency read
- key_n  in  2  raw pushbuttons, active low; bit0 = rotate clockwise, bit1 = rotate counter-clockwise; asynchronous to clk
- out_port  out  3  current direction code 0..7
- irq  out  1  level interrupt

Behaviour:
- Clocking and reset: single clock domain. Reset is asynchronous and active-low; every flop returns to its reset value immediately, including in the middle of a debounce or repeat.
- Reset values: out_port=0, irq=0, MODE=0, IE=0, PEND=0, REPEAT=REPEAT_RESET, state=IDLE.
- Register map; unused readdata bits read 0:
  - 0 DIR (rw, bits 2:0).
  - 1 CTRL (rw): bit0 MODE (0 = keys enabled, 1 = CPU only), bit1 IE.
  - 2 STATUS: bit0 PEND, write 1 to clear.
  - 3 REPEAT (rw, bits 15:0).
- Writes: a write takes effect on the clock edge where chipselect=1, write_n=0 and the address matches.
- Key input path:
  - key_n passes through a 2-flop synchroniser and is inverted to k[1:0].
  - Debouncer: a counter reloads on any change of k. The stable value kd updates when the counter has held k unchanged for DEBOUNCE_CYCLES cycles.
  - Effective request: cw = kd==2'b01, ccw = kd==2'b10. kd==2'b11 and kd==2'b00 both mean "no request".
- FSM, evaluated only while MODE=0:
  - IDLE: on cw or ccw, issue one step and go to HOLD; clear the hold counter.
  - HOLD: if the request drops or changes, go to IDLE. When the hold counter reaches HOLD_CYCLES-1, issue a step and go to REPEAT.
  - REPEAT: if the request drops or changes, go to IDLE. A prescaler counts 1024 cycles per tick. When the tick count reaches REPEAT, issue a step and restart the count. REPEAT=0 is treated as 1.
  - Writing MODE=1 forces the FSM to IDLE on the next edge. Key steps are suppressed while MODE=1.
- Step arithmetic: cw gives dir <= dir+1 and ccw gives dir <= dir-1, both in 3-bit wrap-around (7+1 -> 0, 0-1 -> 7).
- Latency: a step updates out_port on the edge following the FSM step decision.
- Arbitration: a CPU write to DIR in the same cycle as a key step wins, and the key step is dropped. A CPU write to DIR never changes FSM state.
- PEND: set on every key step that changes dir; CPU writes to DIR do not set it. A key step and a W1C in the same cycle leave PEND=1 (set wins).
- irq = PEND & IE, registered, so it follows PEND and IE one cycle later.

Optional Feature:
- Macro: STICK_DIR_IRQ_EN.
- Defined: PEND, IE and irq behave as above.
- Undefined: no PEND or IE flops; STATUS reads 0, CTRL bit1 reads 0 and ignores writes, irq is tied to 0.

Decomposition:
- Package stick_dir_pkg holds:
  - the register address constants ADDR_DIR=0, ADDR_CTRL=1, ADDR_STATUS=2, ADDR_REPEAT=3;
  - the FSM state enum {IDLE, HOLD, REPEAT};
  - the direction width constant DIR_W=3;
  - the prescaler constant TICK_DIV=1024.
- One sub-module, stick_key_debounce: synchroniser plus debounce counter, parameterised by DEBOUNCE_CYCLES, outputting kd[1:0].
- The top level holds the FSM, the Avalon register file and the arbitration.

Test Plan:
All scenarios run with DEBOUNCE_CYCLES=4, HOLD_CYCLES=20 and REPEAT=1 (one step per 1024 cycles) unless a line says otherwise.
1. Reset, then read all registers: readdata 0,0,0 and REPEAT_RESET; out_port=0, irq=0.
2. Hold key_n=2'b10 (cw) for 3 cycles then release: no step. Hold it for 10 cycles: out_port goes 0 -> 1 once and PEND=1. With IE=1, irq=1 one cycle after PEND; writing STATUS=1 clears irq.
3. From dir=7, hold cw: first step gives 0 (wrap); after 20 more cycles the next step gives 1; each following step comes 1024 cycles later. Release and the FSM returns to IDLE with no further steps. From dir=0, ccw steps to 7.
4. CPU writes DIR=5 in the same cycle as a key step: out_port=5 and PEND unchanged by that write.
5. Write CTRL=1 (MODE=1) while cw is held in REPEAT: no further steps, FSM goes to IDLE, and a CPU write of DIR=3 gives out_port=3.
6. Assert reset_n=0 during the REPEAT state: out_port=0 and irq=0 immediately. After release, a continuously held key requires a full debounce period plus a fresh first step before out_port changes.
